// File: rtl/serial_nibble_adder_ctrl_pkg.sv
// Shared types and constants for the serial nibble adder.
// Holds the FSM state encoding and the width of one adder slice.
package sna_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sna_state_t;

    localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_adder_cin.sv
// 4-bit ripple adder with carry-in, built from full-adder cells.
// This is the single arithmetic slice that the top steps across the operands.
module nibble_adder_cin
    import sna_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder stepping one nibble slice per clock, LSB nibble first.
// Define SNA_SUB_EN to add the op_sub port (a-b via inverted b and carry-in of 1).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and the producer/consumer
// may hold valid high for any number of cycles.
module serial_nibble_adder_ctrl
    import sna_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SNA_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output sna_state_t       dbg_state
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    sna_state_t       state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic             cin_reg, cout_r;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             sub_sel;

    logic [NIB_W-1:0] nib_s;
    logic             nib_c;

`ifdef SNA_SUB_EN
    assign sub_sel = op_sub;
`else
    assign sub_sel = 1'b0;
`endif

    nibble_adder_cin u_slice (
        .a    (a_sh[NIB_W-1:0]),
        .b    (b_sh[NIB_W-1:0]),
        .cin  (cin_reg),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Subtraction is folded in at latch time so the RUN datapath never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_r   <= '0;
            cin_reg <= 1'b0;
            cout_r  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= a;
                        b_sh    <= sub_sel ? ~b : b;
                        cin_reg <= sub_sel;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> NIB_W;
                    b_sh    <= b_sh >> NIB_W;
                    sum_r   <= {nib_s, sum_r[WIDTH-1:NIB_W]};
                    cin_reg <= nib_c;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) cout_r <= nib_c;
                end
                default: ;
            endcase
        end
    end

    assign sum       = sum_r;
    assign carry_out = cout_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// Directed bench for serial_nibble_adder_ctrl (WIDTH=16).
// Table-driven vectors plus hand-written stall, reset-abort and back-to-back sequences.
module tb_serial_nibble_adder_ctrl;
    import sna_pkg::*;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH:0]   exp;   // {carry_out, sum}
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_sub_drv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    sna_state_t       dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [WIDTH:0] exp_q[$];

    serial_nibble_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SNA_SUB_EN
        .op_sub    (op_sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drives one operation, checks latency and result, then completes the handshake.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vs, input logic [WIDTH:0] exp);
        int lat;
        logic [WIDTH:0] e;
        @(negedge clk);
        a = va; b = vb; op_sub_drv = vs; in_valid = 1'b1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        e = exp_q.pop_front();
        check({tag, " sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
        check({tag, " carry_out"}, 32'(carry_out), 32'(e[WIDTH]));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid fall"}, 32'(out_valid), 32'd0);
        check({tag, " back to idle"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   acc_t[3];
        logic [WIDTH:0] e;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 17'h0_5555};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h1_0000};
        vecs[2] = '{16'h0F0F, 16'h0101, 1'b0, 17'h0_1010};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 17'h1_0000};
        vecs[4] = '{16'hABCD, 16'h1111, 1'b0, 17'h0_BCDE};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 17'h0_0000};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1_FFFE};
        vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 17'h0_1000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op_sub_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset carry_out", 32'(carry_out), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp);

        // Consumer stalls in DONE while producer keeps offering new operands
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        exp_q.push_back(17'h0_3333);
        @(posedge clk); #1;
        a = 16'hDEAD; b = 16'hBEEF;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stall latency", 32'(lat), 32'd4);
        e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d sum", k), 32'(sum), 32'(e[WIDTH-1:0]));
            check($sformatf("stall%0d carry_out", k), 32'(carry_out), 32'(e[WIDTH]));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stall release out_valid", 32'(out_valid), 32'd0);

        // Reset pulse after the second RUN edge aborts the operation
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort state", 32'(dbg_state), 32'(IDLE));
        check("abort in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after abort", 16'h0F0F, 16'h0101, 1'b0, 17'h0_1010);

`ifdef SNA_SUB_EN
        run_op("sub 7-5", 16'h0007, 16'h0005, 1'b1, 17'h1_0002);
        run_op("sub 5-7", 16'h0005, 16'h0007, 1'b1, 17'h0_FFFE);
        op_sub_drv = 1'b0;
`endif

        // Back-to-back: in_valid and out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = vecs[i + 2].a; b = vecs[i + 2].b; in_valid = 1'b1;
            lat = 0;
            while (!in_ready && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            exp_q.push_back(vecs[i + 2].exp);
            @(posedge clk); #1;
            acc_t[i] = cyc;
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            e = exp_q.pop_front();
            check($sformatf("b2b%0d sum", i), 32'(sum), 32'(e[WIDTH-1:0]));
            check($sformatf("b2b%0d carry_out", i), 32'(carry_out), 32'(e[WIDTH]));
            if (i > 0)
                check($sformatf("b2b%0d issue interval", i), 32'(acc_t[i] - acc_t[i-1]), 32'd6);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b drained", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
